// File: rtl/target_pkg.sv
// Shared definitions for the frog target path: field widths, playfield limits,
// fallback position and the tracker state encoding used by generator and VGA draw.
package target_pkg;

    localparam int X_BITS     = 8;
    localparam int Y_BITS     = 7;
    localparam int ADDR_BITS  = X_BITS + Y_BITS;
    localparam int SCORE_BITS = 8;
    localparam int RETRY_BITS = 4;

    localparam logic [X_BITS-1:0]     X_MAX      = 8'd160;
    localparam logic [Y_BITS-1:0]     Y_MAX      = 7'd120;
    localparam logic [X_BITS-1:0]     DEFAULT_X  = 8'd80;
    localparam logic [Y_BITS-1:0]     DEFAULT_Y  = 7'd60;
    localparam logic [RETRY_BITS-1:0] MAX_RETRY  = 4'd15;
    localparam logic [RETRY_BITS-1:0] RETRY_LAST = MAX_RETRY - 4'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/target_addr_check.sv
// Combinational acceptance test for a candidate target: inside the playfield
// and not sitting on the snake head.
module target_addr_check
    import target_pkg::*;
(
    input  logic [X_BITS-1:0] cand_x,
    input  logic [Y_BITS-1:0] cand_y,
    input  logic [X_BITS-1:0] head_x,
    input  logic [Y_BITS-1:0] head_y,
    output logic              accept
);

    logic in_range;
    logic on_head;

    assign in_range = (cand_x < X_MAX) && (cand_y < Y_MAX);
    assign on_head  = (cand_x == head_x) && (cand_y == head_y);
    assign accept   = in_range && !on_head;

endmodule

// File: rtl/target_tracker.sv
// Owns the current frog target: requests random addresses, validates and latches
// them, detects the head eating the target and keeps a saturating score.
module target_tracker
    import target_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  game_active,
    input  logic                  head_valid,
    input  logic [X_BITS-1:0]     head_x,
    input  logic [Y_BITS-1:0]     head_y,
    input  logic [ADDR_BITS-1:0]  rnd_addr,
    output logic                  target_ate,
    output logic [X_BITS-1:0]     target_x,
    output logic [Y_BITS-1:0]     target_y,
    output logic                  target_valid,
    output logic [SCORE_BITS-1:0] score,
    output logic                  score_evt
);

    state_t                  state, state_nx;
    logic [RETRY_BITS-1:0]   retry_cnt, retry_nx;
    logic [X_BITS-1:0]       tx_nx;
    logic [Y_BITS-1:0]       ty_nx;
    logic                    tv_nx;
    logic [SCORE_BITS-1:0]   score_nx;
    logic                    evt_nx;
    logic                    ate_nx;
    logic [X_BITS-1:0]       smp_x;
    logic [Y_BITS-1:0]       smp_y;
    logic                    accept;
    logic                    eat;

    assign smp_x = rnd_addr[ADDR_BITS-1:Y_BITS];
    assign smp_y = rnd_addr[Y_BITS-1:0];
    assign eat   = head_valid && (head_x == target_x) && (head_y == target_y);

    target_addr_check u_check (
        .cand_x (smp_x),
        .cand_y (smp_y),
        .head_x (head_x),
        .head_y (head_y),
        .accept (accept)
    );

    // Dropping game_active outranks any accept or eat in the same cycle.
    always_comb begin
        state_nx = state;
        retry_nx = retry_cnt;
        tx_nx    = target_x;
        ty_nx    = target_y;
        tv_nx    = target_valid;
        score_nx = score;
        evt_nx   = 1'b0;
        if (!game_active) begin
            state_nx = IDLE;
            tv_nx    = 1'b0;
            retry_nx = '0;
        end else begin
            case (state)
                IDLE: state_nx = REQ;
                REQ: begin
                    if (accept) begin
                        tx_nx    = smp_x;
                        ty_nx    = smp_y;
                        tv_nx    = 1'b1;
                        retry_nx = '0;
                        state_nx = HOLD;
                    end else if (retry_cnt == RETRY_LAST) begin
                        tx_nx    = DEFAULT_X;
                        ty_nx    = DEFAULT_Y;
                        tv_nx    = 1'b1;
                        retry_nx = '0;
                        state_nx = HOLD;
                    end else begin
                        retry_nx = retry_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (eat) begin
                        evt_nx   = 1'b1;
                        tv_nx    = 1'b0;
                        state_nx = REQ;
                        if (!(&score)) begin
                            score_nx = score + 1'b1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        ate_nx = (state_nx == REQ);
    end

    // The request line is registered from the next state so it tracks REQ exactly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            retry_cnt    <= '0;
            target_x     <= '0;
            target_y     <= '0;
            target_valid <= 1'b0;
            score        <= '0;
            score_evt    <= 1'b0;
            target_ate   <= 1'b0;
        end else begin
            state        <= state_nx;
            retry_cnt    <= retry_nx;
            target_x     <= tx_nx;
            target_y     <= ty_nx;
            target_valid <= tv_nx;
            score        <= score_nx;
            score_evt    <= evt_nx;
            target_ate   <= ate_nx;
        end
    end

endmodule

// File: tb/tb_target_tracker.sv
// Directed bench for target_tracker: request/accept, rejects, fallback,
// eating, score saturation, game abort and reset.
module tb_target_tracker;

    logic        clk;
    logic        reset;
    logic        game_active;
    logic        head_valid;
    logic [7:0]  head_x;
    logic [6:0]  head_y;
    logic [14:0] rnd_addr;
    logic        target_ate;
    logic [7:0]  target_x;
    logic [6:0]  target_y;
    logic        target_valid;
    logic [7:0]  score;
    logic        score_evt;

    int n_total;
    int n_bad;

    target_tracker dut (
        .clk          (clk),
        .reset        (reset),
        .game_active  (game_active),
        .head_valid   (head_valid),
        .head_x       (head_x),
        .head_y       (head_y),
        .rnd_addr     (rnd_addr),
        .target_ate   (target_ate),
        .target_x     (target_x),
        .target_y     (target_y),
        .target_valid (target_valid),
        .score        (score),
        .score_evt    (score_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        if (observed !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it in, and settle just after the edge.
    task automatic applyStimulus(input logic ga, input logic hv, input logic [7:0] hx,
                                 input logic [6:0] hy, input logic [7:0] rx, input logic [6:0] ry);
        game_active = ga;
        head_valid  = hv;
        head_x      = hx;
        head_y      = hy;
        rnd_addr    = {rx, ry};
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        reset       = 1'b0;
        game_active = 1'b0;
        head_valid  = 1'b0;
        head_x      = '0;
        head_y      = '0;
        rnd_addr    = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ate",   32'(target_ate),   0);
        checkOutput("rst_x",     32'(target_x),     0);
        checkOutput("rst_y",     32'(target_y),     0);
        checkOutput("rst_valid", 32'(target_valid), 0);
        checkOutput("rst_score", 32'(score),        0);
        checkOutput("rst_evt",   32'(score_evt),    0);

        reset = 1'b1;
        applyStimulus(1, 0, 0, 0, 20, 30);
        checkOutput("start_ate",   32'(target_ate),   1);
        checkOutput("start_valid", 32'(target_valid), 0);
        applyStimulus(1, 0, 0, 0, 20, 30);
        checkOutput("acc1_x",     32'(target_x),     20);
        checkOutput("acc1_y",     32'(target_y),     30);
        checkOutput("acc1_valid", 32'(target_valid), 1);
        checkOutput("acc1_ate",   32'(target_ate),   0);

        applyStimulus(1, 0, 20, 30, 20, 30);
        checkOutput("stale_score", 32'(score),        0);
        checkOutput("stale_valid", 32'(target_valid), 1);
        applyStimulus(1, 1, 20, 30, 20, 30);
        checkOutput("eat1_score", 32'(score),        1);
        checkOutput("eat1_evt",   32'(score_evt),    1);
        checkOutput("eat1_ate",   32'(target_ate),   1);
        checkOutput("eat1_valid", 32'(target_valid), 0);

        applyStimulus(1, 0, 20, 30, 200, 0);
        checkOutput("rejx_evt", 32'(score_evt), 0);
        checkOutput("rejx_ate", 32'(target_ate), 1);
        applyStimulus(1, 0, 20, 30, 5, 127);
        checkOutput("rejy_valid", 32'(target_valid), 0);
        applyStimulus(1, 0, 20, 30, 5, 5);
        checkOutput("acc2_x",     32'(target_x),     5);
        checkOutput("acc2_y",     32'(target_y),     5);
        checkOutput("acc2_valid", 32'(target_valid), 1);

        applyStimulus(1, 1, 5, 5, 0, 0);
        checkOutput("eat2_score", 32'(score), 2);
        applyStimulus(1, 0, 20, 30, 20, 30);
        checkOutput("rejhead_valid", 32'(target_valid), 0);
        checkOutput("rejhead_ate",   32'(target_ate),   1);
        applyStimulus(1, 0, 20, 30, 159, 119);
        checkOutput("edge_x", 32'(target_x), 159);
        checkOutput("edge_y", 32'(target_y), 119);

        applyStimulus(1, 1, 159, 119, 200, 0);
        checkOutput("eat3_score", 32'(score), 3);
        repeat (14) applyStimulus(1, 0, 0, 0, 200, 0);
        checkOutput("retry14_ate",   32'(target_ate),   1);
        checkOutput("retry14_valid", 32'(target_valid), 0);
        applyStimulus(1, 0, 0, 0, 200, 0);
        checkOutput("fb_x",     32'(target_x),     80);
        checkOutput("fb_y",     32'(target_y),     60);
        checkOutput("fb_valid", 32'(target_valid), 1);

        applyStimulus(1, 1, 80, 60, 200, 0);
        checkOutput("eat4_score", 32'(score), 4);
        repeat (14) applyStimulus(1, 0, 0, 0, 200, 0);
        checkOutput("retry_clr_valid", 32'(target_valid), 0);
        applyStimulus(1, 0, 0, 0, 10, 10);
        checkOutput("retry_clr_x", 32'(target_x), 10);
        checkOutput("retry_clr_y", 32'(target_y), 10);

        for (int i = 0; i < 251; i++) begin
            applyStimulus(1, 1, 10, 10, 10, 10);
            applyStimulus(1, 0, 0, 0, 10, 10);
        end
        checkOutput("sat_pre_score", 32'(score), 255);
        applyStimulus(1, 1, 10, 10, 10, 10);
        checkOutput("sat_score", 32'(score),     255);
        checkOutput("sat_evt",   32'(score_evt), 1);

        applyStimulus(0, 0, 0, 0, 10, 10);
        checkOutput("abort_ate",   32'(target_ate),   0);
        checkOutput("abort_valid", 32'(target_valid), 0);
        checkOutput("abort_score", 32'(score),        255);
        applyStimulus(1, 0, 0, 0, 10, 10);
        checkOutput("resume_ate", 32'(target_ate), 1);

        reset = 1'b0;
        applyStimulus(1, 0, 0, 0, 10, 10);
        checkOutput("midrst_ate",   32'(target_ate),   0);
        checkOutput("midrst_valid", 32'(target_valid), 0);
        checkOutput("midrst_x",     32'(target_x),     0);
        checkOutput("midrst_score", 32'(score),        0);
        reset = 1'b1;

        applyStimulus(1, 0, 0, 0, 10, 10);
        applyStimulus(1, 0, 0, 0, 10, 10);
        checkOutput("re_acc_valid", 32'(target_valid), 1);
        applyStimulus(0, 1, 10, 10, 10, 10);
        checkOutput("abort_eat_score", 32'(score),        0);
        checkOutput("abort_eat_evt",   32'(score_evt),    0);
        checkOutput("abort_eat_valid", 32'(target_valid), 0);
        checkOutput("abort_eat_ate",   32'(target_ate),   0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
